pipelined_cla_adder: RTL
========================

# pipelined_cla_adder

- Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit CLA groups.
- One 4-bit group is resolved per pipeline stage, so the carry is registered between groups and the clock period is independent of WIDTH.
- Valid/ready handshakes on input and output let it sit in a datapath with backpressure. It replaces the single-cycle 4-bit CLA wherever wide operands are needed.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 4; GROUPS = WIDTH/4.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block accepts operands this cycle.
- A  input  WIDTH  operand A (unsigned / two's complement).
- B  input  WIDTH  operand B.
- cin  input  1  carry in; ignored when sub=1.
- sub  input  1  0: A+B+cin; 1: A−B.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result this cycle.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB (for subtraction, 1 = no borrow).
- ovf  output  1  signed overflow; present only with CLA_OVF_EN.

## Operation
- Subtraction: B is replaced by ~B and the carry-in is forced to 1 at acceptance; cin is ignored.
- Pipeline of GROUPS stages. Each stage holds a valid bit, the carry into the next group, the completed low sum bits, and the unprocessed high bits of A and (possibly inverted) B.
- Stage k computes sum[4k+3:4k] and its group carry with 4-bit lookahead (g = a&b, p = a^b; c1..c4 from lookahead equations, no ripple inside the group).
- The final stage drives sum, cout and ovf. ovf = carry into MSB XOR carry out of MSB.
- Stage k loads when it is empty or its downstream stage loads/drains that cycle. The last stage drains on out_valid && out_ready.
- in_ready = load-enable of stage 0. A combinational path out_ready → in_ready is permitted.
- Transfer occurs on valid && ready at a rising edge.
- Bubbles collapse: an empty stage always loads from upstream.
- Results leave in acceptance order; none are dropped or duplicated.
- Capacity: GROUPS transactions in flight.
- While out_valid && !out_ready, sum/cout/ovf hold stable.
- Arithmetic is modulo 2^WIDTH; no saturation.

## Timing
- Latency: an operand accepted at edge n gives out_valid=1 after edge n+GROUPS-1 when not stalled. For WIDTH=4, the result is valid one cycle after acceptance.
- Throughput: one result per cycle with out_ready held high.
- Reset values:
  - all stage valid bits 0;
  - out_valid=0, sum=0, cout=0, ovf=0;
  - in_ready=1 combinationally once rst deasserts.
- Reset mid-operation: all in-flight transactions are discarded immediately (asynchronous). No output pulse follows deassertion.
- Full pipeline with out_ready=0: in_ready=0.
- Full pipeline with out_ready=1 in the same cycle: in_ready=1, and a new input is accepted while the head result drains.
- in_valid while in_ready=0: not accepted. The producer must hold A/B/cin/sub stable until acceptance.
- sub and cin are sampled only at acceptance.

## Configuration
- CLA_OVF_EN defined: ovf port exists and carries signed overflow, pipelined with sum.
- CLA_OVF_EN undefined: no ovf port and no MSB-carry tracking logic. All other behaviour is identical.

## Test plan
- Propagate chain (WIDTH=16):
  - A=16'h8000, B=16'h7FFF, cin=0 -> sum=16'hFFFF, cout=0;
  - same with cin=1 -> sum=16'h0000, cout=1.
  - Both results appear 3 cycles after acceptance.
- Subtraction (WIDTH=16):
  - A=5, B=7, sub=1, cin=1 -> sum=16'hFFFE, cout=0 (cin ignored);
  - A=7, B=5, sub=1 -> sum=2, cout=1.
- Backpressure (WIDTH=16): hold out_ready=0 and offer 6 back-to-back inputs (1+1, 2+2, … 6+6) -> exactly 4 accepted and in_ready=0. Then out_ready=1 -> results 2,4,6,8,10,12 in order, no gaps once flowing.
- Overflow with CLA_OVF_EN:
  - A=16'h7FFF, B=1 -> sum=16'h8000, ovf=1, cout=0;
  - A=16'hFFFF, B=1 -> sum=0, ovf=0, cout=1.
- Reset mid-stream: 3 transactions in flight, assert rst for 1 cycle -> out_valid=0 and sum=0 immediately. After deassertion, no stale result ever appears and in_ready=1.
- WIDTH=4 instance: A=4'd10, B=4'd5, cin=1 -> sum=0, cout=1 one cycle after acceptance.

Source files
------------

// File: rtl/pipelined_cla_adder_if.sv
// Valid/ready operand and result bus for pipelined_cla_adder.
// ovf is present only when CLA_OVF_EN is defined.
interface pipelined_cla_adder_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef CLA_OVF_EN
   logic             ovf;
`endif

   // Producer/consumer side of the adder
   modport master (
      output in_valid, A, B, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout
`ifdef CLA_OVF_EN
      , input ovf
`endif
   );

   // Adder side
   modport slave (
      input  in_valid, A, B, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout
`ifdef CLA_OVF_EN
      , output ovf
`endif
   );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor, one 4-bit CLA group per stage.
// Define CLA_OVF_EN to add the signed-overflow output.
module pipelined_cla_adder #(
   parameter int unsigned WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   pipelined_cla_adder_if.slave bus
);
   localparam int unsigned GROUPS = WIDTH / 4;

   // 4-bit lookahead group: returns {carry_out, sum[3:0]}
   function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                       input logic c0);
      logic [3:0] g;
      logic [3:0] p;
      logic       c1;
      logic       c2;
      logic       c3;
      logic       c4;
      g  = a & b;
      p  = a ^ b;
      c1 = g[0] | (p[0] & c0);
      c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
      return {c4, p ^ {c3, c2, c1, c0}};
   endfunction

   logic [GROUPS-1:0]            vld_q, vld_d;
   logic [GROUPS-1:0]            cry_q, cry_d;
   logic [GROUPS-1:0]            ld_c;
   logic [GROUPS-1:0][WIDTH-1:0] a_q, a_d;
   logic [GROUPS-1:0][WIDTH-1:0] b_q, b_d;
   logic [GROUPS-1:0][WIDTH-1:0] s_q, s_d;
   logic [WIDTH-1:0]             b_in_c;
   logic                         c_in_c;
   logic [4:0]                   grp_c;
`ifdef CLA_OVF_EN
   logic                         ovf_q, ovf_d;
`endif

   // A stage loads when empty or when its downstream stage moves on
   always_comb begin
      ld_c           = '0;
      ld_c[GROUPS-1] = !vld_q[GROUPS-1] || bus.out_ready;
      for (int k = int'(GROUPS) - 2; k >= 0; k--) begin
         ld_c[k] = !vld_q[k] || ld_c[k+1];
      end
   end

   always_comb begin
      vld_d  = vld_q;
      cry_d  = cry_q;
      a_d    = a_q;
      b_d    = b_q;
      s_d    = s_q;
      grp_c  = '0;
      b_in_c = bus.sub ? ~bus.B : bus.B;
      c_in_c = bus.sub | bus.cin;
`ifdef CLA_OVF_EN
      ovf_d  = ovf_q;
`endif

      if (ld_c[0]) begin
         vld_d[0] = bus.in_valid;
         if (bus.in_valid) begin
            grp_c       = cla4(bus.A[3:0], b_in_c[3:0], c_in_c);
            a_d[0]      = bus.A;
            b_d[0]      = b_in_c;
            s_d[0]      = '0;
            s_d[0][3:0] = grp_c[3:0];
            cry_d[0]    = grp_c[4];
         end
      end

      for (int k = 1; k < int'(GROUPS); k++) begin
         if (ld_c[k]) begin
            vld_d[k] = vld_q[k-1];
            if (vld_q[k-1]) begin
               grp_c             = cla4(a_q[k-1][4*k +: 4], b_q[k-1][4*k +: 4], cry_q[k-1]);
               a_d[k]            = a_q[k-1];
               b_d[k]            = b_q[k-1];
               s_d[k]            = s_q[k-1];
               s_d[k][4*k +: 4]  = grp_c[3:0];
               cry_d[k]          = grp_c[4];
            end
         end
      end

`ifdef CLA_OVF_EN
      // Carry into the MSB is recovered as sum^a^b at that bit
      if (ld_c[GROUPS-1] && vld_d[GROUPS-1]) begin
         ovf_d = cry_d[GROUPS-1] ^ s_d[GROUPS-1][WIDTH-1]
               ^ a_d[GROUPS-1][WIDTH-1] ^ b_d[GROUPS-1][WIDTH-1];
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         cry_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
         s_q   <= '0;
`ifdef CLA_OVF_EN
         ovf_q <= 1'b0;
`endif
      end else begin
         vld_q <= vld_d;
         cry_q <= cry_d;
         a_q   <= a_d;
         b_q   <= b_d;
         s_q   <= s_d;
`ifdef CLA_OVF_EN
         ovf_q <= ovf_d;
`endif
      end
   end

   // Last-stage operand copies only matter for overflow
   logic unused_last_ops;
   assign unused_last_ops = ^{a_q[GROUPS-1], b_q[GROUPS-1]};

   assign bus.in_ready  = ld_c[0];
   assign bus.out_valid = vld_q[GROUPS-1];
   assign bus.sum       = s_q[GROUPS-1];
   assign bus.cout      = cry_q[GROUPS-1];
`ifdef CLA_OVF_EN
   assign bus.ovf       = ovf_q;
`endif
endmodule
